tlb_op_ctrl: RTL and testbench

//  Multi-cycle sequencer for the TLB-management instructions (TLBP/TLBR/TLBWI/TLBWR) in the M stage.

---
 rtl/tlb_op_ctrl_if.sv | 38 +++
 rtl/tlb_op_ctrl.sv | 66 ++++++
 tb/tb_tlb_op_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: pipeline, TLB and CP0 signals of the TLB-instruction sequencer
interface tlb_op_ctrl_if #(parameter int LOG2_TLB_LINE_NUM = 5);
  logic op_valid;
  logic [1:0] op_type;
  logic [31:0] op_pc;
  logic exc_flushM;
  logic stall_other;
  logic tlbp_o, tlbr_o, tlbwi_o, tlbwr_o;
  logic [31:0] random_o;
  logic [31:0] tlb_index_in, tlb_hi_in, tlb_pm_in, tlb_lo0_in, tlb_lo1_in;
  logic wired_we;
  logic [LOG2_TLB_LINE_NUM-1:0] wired_wdata;
  logic cp0_index_we;
  logic [31:0] cp0_index_wdata;
  logic cp0_tlbr_we;
  logic [31:0] cp0_hi_wdata, cp0_pm_wdata, cp0_lo0_wdata, cp0_lo1_wdata;
  logic stall_req;
  logic refetch;
  logic [31:0] refetch_pc;
  modport slave (
    input op_valid, op_type, op_pc, exc_flushM, stall_other,
    input tlb_index_in, tlb_hi_in, tlb_pm_in, tlb_lo0_in, tlb_lo1_in,
    input wired_we, wired_wdata,
    output tlbp_o, tlbr_o, tlbwi_o, tlbwr_o, random_o,
    output cp0_index_we, cp0_index_wdata, cp0_tlbr_we,
    output cp0_hi_wdata, cp0_pm_wdata, cp0_lo0_wdata, cp0_lo1_wdata,
    output stall_req, refetch, refetch_pc
  );
  modport master (
    output op_valid, op_type, op_pc, exc_flushM, stall_other,
    output tlb_index_in, tlb_hi_in, tlb_pm_in, tlb_lo0_in, tlb_lo1_in,
    output wired_we, wired_wdata,
    input tlbp_o, tlbr_o, tlbwi_o, tlbwr_o, random_o,
    input cp0_index_we, cp0_index_wdata, cp0_tlbr_we,
    input cp0_hi_wdata, cp0_pm_wdata, cp0_lo0_wdata, cp0_lo1_wdata,
    input stall_req, refetch, refetch_pc
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: M-stage sequencer for TLBP/TLBR/TLBWI/TLBWR plus the CP0 Random counter
module tlb_op_ctrl #(
  parameter int TLB_LINE_NUM = 32,
  parameter int LOG2_TLB_LINE_NUM = 5
) (
  input logic clk,
  input logic rst,
  tlb_op_ctrl_if.slave bus
);
  localparam logic [LOG2_TLB_LINE_NUM-1:0] RMAX = LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);
  typedef enum logic [1:0] {IDLE, EXEC, WB, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op_q;
  logic [31:0] pc4_q;
  logic [LOG2_TLB_LINE_NUM-1:0] rnd, wired, rnd_snap;
  logic [31:0] idx_q, hi_q, pm_q, lo0_q, lo1_q;
  logic accept, ex, wb;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      pc4_q <= '0;
      rnd_snap <= '0;
      rnd <= RMAX;
      wired <= '0;
      {idx_q, hi_q, pm_q, lo0_q, lo1_q} <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= bus.op_type;
        pc4_q <= bus.op_pc + 32'd4;
        rnd_snap <= rnd;
      end
      if (state == EXEC)
        {idx_q, hi_q, pm_q, lo0_q, lo1_q} <= {bus.tlb_index_in, bus.tlb_hi_in, bus.tlb_pm_in, bus.tlb_lo0_in, bus.tlb_lo1_in};
      if (bus.wired_we) begin
        rnd <= RMAX;
        wired <= bus.wired_wdata;
      end else
        rnd <= (rnd <= wired || wired >= RMAX) ? RMAX : rnd - 1'b1;
    end
  end
  // Outputs are masked during rst so a reset landing in EXEC never leaks a TLB command.
  always_comb begin
    accept = state == IDLE && bus.op_valid && !bus.exc_flushM;
    state_n = accept ? EXEC : state == EXEC ? WB : state == WB ? DONE :
              state == DONE && !bus.stall_other ? IDLE : state;
    ex = !rst && state == EXEC;
    wb = !rst && state == WB;
    bus.stall_req = !rst && (accept || state == EXEC || state == WB);
    bus.tlbp_o = ex && op_q == 2'b00;
    bus.tlbr_o = ex && op_q == 2'b01;
    bus.tlbwi_o = ex && op_q == 2'b10;
    bus.tlbwr_o = ex && op_q == 2'b11;
    bus.random_o = {{(32 - LOG2_TLB_LINE_NUM){1'b0}}, rnd_snap};
    bus.cp0_index_we = wb && op_q == 2'b00;
    bus.cp0_tlbr_we = wb && op_q == 2'b01;
    bus.cp0_index_wdata = idx_q;
    bus.cp0_hi_wdata = hi_q;
    bus.cp0_pm_wdata = pm_q;
    bus.cp0_lo0_wdata = lo0_q;
    bus.cp0_lo1_wdata = lo1_q;
    bus.refetch = !rst && state == DONE && !bus.stall_other && op_q != 2'b00;
    bus.refetch_pc = pc4_q;
  end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed and randomized checks of tlb_op_ctrl against a cycle-level reference model
module tb_tlb_op_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tlb_op_ctrl_if bus();
  tlb_op_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [4:0] m_rand, m_wired;
  logic [3:0] pulses;
  assign pulses = {bus.tlbp_o, bus.tlbr_o, bus.tlbwi_o, bus.tlbwr_o};
  // Random register rules: a Wired write resets to 31, otherwise count down and wrap above Wired.
  always @(posedge clk) begin
    if (rst) begin
      m_rand <= 5'd31;
      m_wired <= 5'd0;
    end else if (bus.wired_we) begin
      m_rand <= 5'd31;
      m_wired <= bus.wired_wdata;
    end else if (m_rand <= m_wired || m_wired == 5'd31)
      m_rand <= 5'd31;
    else
      m_rand <= m_rand - 5'd1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic misc(input bit rw);
    bus.wired_we = rw && $urandom_range(0, 7) == 0;
    bus.wired_wdata = 5'($urandom_range(0, 20));
  endtask
  task automatic run_op(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] idx,
                        input logic [31:0] lo0, input int nstall, input bit rw);
    logic [4:0] snap;
    logic [31:0] hi, pm, lo1;
    hi = $urandom;
    pm = $urandom;
    lo1 = $urandom;
    bus.op_valid = 1'b1;
    bus.op_type = t;
    bus.op_pc = pc;
    bus.exc_flushM = 1'b0;
    bus.stall_other = 1'b0;
    misc(rw);
    #1;
    chk("accept_stall", 32'(bus.stall_req), 32'd1);
    chk("accept_pulse", 32'(pulses), 32'd0);
    snap = m_rand;
    cyc;
    bus.tlb_index_in = idx;
    bus.tlb_hi_in = hi;
    bus.tlb_pm_in = pm;
    bus.tlb_lo0_in = lo0;
    bus.tlb_lo1_in = lo1;
    bus.exc_flushM = 1'($urandom_range(0, 1));
    misc(rw);
    #1;
    chk("exec_stall", 32'(bus.stall_req), 32'd1);
    chk("exec_pulse", 32'(pulses), 32'(4'b1000 >> t));
    if (t == 2'b11) chk("exec_random", bus.random_o, {27'd0, snap});
    cyc;
    {bus.tlb_index_in, bus.tlb_hi_in, bus.tlb_pm_in, bus.tlb_lo0_in, bus.tlb_lo1_in} = {$urandom, $urandom, $urandom, $urandom, $urandom};
    misc(rw);
    #1;
    chk("wb_stall", 32'(bus.stall_req), 32'd1);
    chk("wb_pulse", 32'(pulses), 32'd0);
    chk("wb_index_we", 32'(bus.cp0_index_we), 32'(t == 2'b00));
    chk("wb_tlbr_we", 32'(bus.cp0_tlbr_we), 32'(t == 2'b01));
    if (t == 2'b00) chk("wb_index_wdata", bus.cp0_index_wdata, idx);
    if (t == 2'b01) begin
      chk("wb_hi", bus.cp0_hi_wdata, hi);
      chk("wb_pm", bus.cp0_pm_wdata, pm);
      chk("wb_lo0", bus.cp0_lo0_wdata, lo0);
      chk("wb_lo1", bus.cp0_lo1_wdata, lo1);
    end
    cyc;
    bus.op_valid = 1'b0;
    bus.exc_flushM = 1'b0;
    for (int i = 0; i < nstall; i++) begin
      bus.stall_other = 1'b1;
      misc(rw);
      #1;
      chk("hold_stall", 32'(bus.stall_req), 32'd0);
      chk("hold_refetch", 32'(bus.refetch), 32'd0);
      chk("hold_strobes", 32'({bus.cp0_index_we, bus.cp0_tlbr_we}), 32'd0);
      cyc;
    end
    bus.stall_other = 1'b0;
    misc(rw);
    #1;
    chk("done_stall", 32'(bus.stall_req), 32'd0);
    chk("done_refetch", 32'(bus.refetch), 32'(t != 2'b00));
    if (t != 2'b00) chk("done_refetch_pc", bus.refetch_pc, pc + 32'd4);
    cyc;
    bus.wired_we = 1'b0;
    #1;
    chk("idle_refetch", 32'(bus.refetch), 32'd0);
    chk("idle_stall", 32'(bus.stall_req), 32'd0);
    chk("idle_pulse", 32'(pulses), 32'd0);
  endtask
  initial begin
    bus.op_valid = 1'b0;
    bus.op_type = 2'b00;
    bus.op_pc = '0;
    bus.exc_flushM = 1'b0;
    bus.stall_other = 1'b0;
    {bus.tlb_index_in, bus.tlb_hi_in, bus.tlb_pm_in, bus.tlb_lo0_in, bus.tlb_lo1_in} = '0;
    bus.wired_we = 1'b0;
    bus.wired_wdata = '0;
    cyc;
    cyc;
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_pulse", 32'(pulses), 32'd0);
    chk("rst_refetch", 32'(bus.refetch), 32'd0);
    chk("rst_random", bus.random_o, 32'd0);
    chk("rst_refetch_pc", bus.refetch_pc, 32'd0);
    chk("rst_index_wdata", bus.cp0_index_wdata, 32'd0);
    rst = 1'b0;
    cyc;
    for (int i = 0; i < 40 && m_rand != 5'd7; i++) cyc;
    chk("wait_rand7", 32'(m_rand), 32'd7);
    run_op(2'b11, 32'hBFC0_0100, 32'd0, 32'd0, 0, 1'b0);
    run_op(2'b00, 32'h8000_0200, 32'd5, 32'd0, 0, 1'b0);
    run_op(2'b00, 32'h8000_0204, 32'h8000_0000, 32'd0, 0, 1'b0);
    run_op(2'b01, 32'h8000_0208, 32'd0, 32'h0001_2347, 0, 1'b0);
    bus.op_valid = 1'b1;
    bus.op_type = 2'b11;
    bus.exc_flushM = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall_req), 32'd0);
    cyc;
    bus.op_valid = 1'b0;
    bus.exc_flushM = 1'b0;
    #1;
    chk("flush_pulse", 32'(pulses), 32'd0);
    chk("flush_stall_after", 32'(bus.stall_req), 32'd0);
    cyc;
    bus.wired_we = 1'b1;
    bus.wired_wdata = 5'd8;
    cyc;
    bus.wired_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 30)) cyc;
      run_op(2'b11, $urandom, 32'd0, 32'd0, 0, 1'b0);
    end
    for (int i = 0; i < 40 && m_rand != 5'd8; i++) cyc;
    chk("wait_rand8", 32'(m_rand), 32'd8);
    bus.wired_we = 1'b1;
    bus.wired_wdata = 5'd3;
    cyc;
    bus.wired_we = 1'b0;
    run_op(2'b11, 32'h1000_0000, 32'd0, 32'd0, 0, 1'b0);
    bus.wired_we = 1'b1;
    bus.wired_wdata = 5'd31;
    cyc;
    bus.wired_we = 1'b0;
    repeat (5) cyc;
    run_op(2'b11, 32'h1000_0010, 32'd0, 32'd0, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFC, 32'd0, 32'd0, 4, 1'b0);
    bus.op_valid = 1'b1;
    bus.op_type = 2'b01;
    bus.op_pc = 32'h2000_0000;
    cyc;
    rst = 1'b1;
    bus.op_valid = 1'b0;
    #1;
    chk("rstx_pulse", 32'(pulses), 32'd0);
    chk("rstx_stall", 32'(bus.stall_req), 32'd0);
    cyc;
    rst = 1'b0;
    #1;
    chk("rstx_idle_stall", 32'(bus.stall_req), 32'd0);
    chk("rstx_idle_strobe", 32'({bus.cp0_index_we, bus.cp0_tlbr_we}), 32'd0);
    chk("rstx_idle_pulse", 32'(pulses), 32'd0);
    cyc;
    chk("rstx_no_strobe", 32'({bus.cp0_index_we, bus.cp0_tlbr_we}), 32'd0);
    cyc;
    chk("rstx_no_refetch", 32'(bus.refetch), 32'd0);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) begin
        misc(1'b1);
        cyc;
      end
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
